// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit
//   Memory-stage access unit. Serves a word-addressed data RAM and a small
//   memory-mapped peripheral window (timer, LEDs, 7-segment digits, cycle
//   counter). Load data is returned combinationally in the same cycle.
//
//   Optional feature macro: MMIO_TIMER_EN
//     defined   -> TH/TL/TCON timer with level interrupt is built
//     undefined -> timer addresses read 0 / ignore writes, o_irq = 0
//
//   Ports
//     clk           system clock, all state updates on posedge
//     reset         asynchronous active-high reset
//     i_mem_read    load request
//     i_mem_write   store request
//     i_addr        byte address (bits [1:0] ignored)
//     i_write_data  store data
//     o_read_data   load data (0 when i_mem_read = 0)
//     o_leds        LED register
//     o_digits      7-segment register ([11:8] anodes, [7:0] segments)
//     o_irq         timer interrupt request (level)
module mem_access_unit #(
  parameter int unsigned RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic [7:0]  o_leds,
  output logic [11:0] o_digits,
  output logic        o_irq
);

  localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  // Word addresses (i_addr[31:2]) of the peripheral registers.
  localparam logic [29:0] W_TH      = 30'h1000_0000;
  localparam logic [29:0] W_TL      = 30'h1000_0001;
  localparam logic [29:0] W_TCON    = 30'h1000_0002;
  localparam logic [29:0] W_LEDS    = 30'h1000_0003;
  localparam logic [29:0] W_DIGITS  = 30'h1000_0004;
  localparam logic [29:0] W_SYSTICK = 30'h1000_0005;

  logic [31:0]   ram [RAM_WORDS];
  logic [29:0]   word;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;

  logic [7:0]    leds_q;
  logic [11:0]   digits_q;
  logic [31:0]   systick_q;

  assign word    = i_addr[31:2];
  assign ram_hit = (i_addr < RAM_BYTES);
  assign ram_idx = i_addr[AW+1:2];

  assign o_leds   = leds_q;
  assign o_digits = digits_q;

  // RAM contents are never cleared; reset only blocks a store in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset && i_mem_write && ram_hit) begin
      ram[ram_idx] <= i_write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q    <= '0;
      digits_q  <= '0;
      systick_q <= '0;
    end else begin
      systick_q <= systick_q + 32'd1;
      if (i_mem_write && word == W_LEDS) begin
        leds_q <= i_write_data[7:0];
      end
      if (i_mem_write && word == W_DIGITS) begin
        digits_q <= i_write_data[11:0];
      end
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] th_q;
  logic [31:0] tl_q;
  logic [2:0]  tcon_q;
  logic        tl_wrap;
  logic        status_set;

  assign tl_wrap    = tcon_q[0] && (tl_q == '1);
  assign status_set = tl_wrap && tcon_q[1];
  assign o_irq      = tcon_q[1] & tcon_q[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      if (i_mem_write && word == W_TH) begin
        th_q <= i_write_data;
      end

      if (i_mem_write && word == W_TL) begin
        tl_q <= i_write_data;
      end else if (tcon_q[0]) begin
        tl_q <= tl_wrap ? th_q : tl_q + 32'd1;
      end

      // A same-cycle overflow overrides a software clear of the status bit.
      if (i_mem_write && word == W_TCON) begin
        tcon_q <= {i_write_data[2] | status_set, i_write_data[1:0]};
      end else if (status_set) begin
        tcon_q[2] <= 1'b1;
      end
    end
  end
`else
  assign o_irq = 1'b0;
`endif

  always_comb begin
    o_read_data = '0;
    if (i_mem_read) begin
      if (ram_hit) begin
        o_read_data = ram[ram_idx];
      end else begin
        case (word)
`ifdef MMIO_TIMER_EN
          W_TH:      o_read_data = th_q;
          W_TL:      o_read_data = tl_q;
          W_TCON:    o_read_data = {29'd0, tcon_q};
`endif
          W_LEDS:    o_read_data = {24'd0, leds_q};
          W_DIGITS:  o_read_data = {20'd0, digits_q};
          W_SYSTICK: o_read_data = systick_q;
          default:   o_read_data = '0;
        endcase
      end
    end
  end

endmodule
